// File: rtl/yarvi_alu_issue_pkg.sv
// Shared constants for the ALU operand-issue stage.
//   - RV32I major opcodes handled by the issue decoder
//   - ALU funct3 selector names (ADDSUB/SLL/SLT/SLTU/XOR/SR_/OR/AND)
//   - helper mapping a branch funct3 onto the ALU compare selector
package yarvi_alu_issue_pkg;

    localparam int ISSUE_XLEN = 32;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADDSUB = 3'b000,
        ALU_SLL    = 3'b001,
        ALU_SLT    = 3'b010,
        ALU_SLTU   = 3'b011,
        ALU_XOR    = 3'b100,
        ALU_SR     = 3'b101,
        ALU_OR     = 3'b110,
        ALU_AND    = 3'b111
    } alu_funct3_e;

    // BEQ/BNE subtract and zero-test, BLT/BGE use SLT, BLTU/BGEU use SLTU.
    // The reserved encodings 010/011 fall to ADDSUB and are flagged illegal
    // by the caller.
    function automatic logic [2:0] branch_funct3(input logic [2:0] f3);
        logic [2:0] sel;
        case (f3[2:1])
            2'b10:   sel = ALU_SLT;
            2'b11:   sel = ALU_SLTU;
            default: sel = ALU_ADDSUB;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/yarvi_alu_decode.sv
// Combinational RV32I -> ALU selector decoder.
//   insn, pc, rs1_val, rs2_val : instruction word and its operands
//   insn30, funct3             : ALU function select
//   op1, op2                   : ALU operands
//   rd                         : writeback register (0 = none)
//   branch                     : result is a branch compare
//   illegal                    : opcode/funct3 not handled
module yarvi_alu_decode
    import yarvi_alu_issue_pkg::*;
#(
    parameter int XLEN = ISSUE_XLEN
) (
    input  logic [31:0]     insn,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            insn30,
    output logic [2:0]      funct3,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [4:0]      rd,
    output logic            branch,
    output logic            illegal
);

    logic [2:0]      f3_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_u_s;

    assign f3_s    = insn[14:12];
    assign imm_i_s = XLEN'($signed(insn[31:20]));
    assign imm_u_s = XLEN'($signed({insn[31:12], 12'h000}));

    // Rewrite the instruction into the ALU's selector encoding.
    always_comb begin
        insn30  = 1'b0;
        funct3  = ALU_ADDSUB;
        op1     = '0;
        op2     = '0;
        rd      = insn[11:7];
        branch  = 1'b0;
        illegal = 1'b0;
        case (insn[6:0])
            OPC_OP: begin
                funct3 = f3_s;
                insn30 = insn[30];
                op1    = rs1_val;
                op2    = rs2_val;
            end
            OPC_OP_IMM: begin
                funct3 = f3_s;
                // Only shifts use bit 30; a negative ADDI must not subtract.
                if (f3_s == ALU_SR) begin
                    insn30 = insn[30];
                end else begin
                    insn30 = 1'b0;
                end
                op1 = rs1_val;
                op2 = imm_i_s;
            end
            OPC_LUI: begin
                op2 = imm_u_s;
            end
            OPC_AUIPC: begin
                op1 = pc;
                op2 = imm_u_s;
            end
            OPC_JAL, OPC_JALR: begin
                op1 = pc;
                op2 = XLEN'(32'd4);
            end
            OPC_BRANCH: begin
                op1    = rs1_val;
                op2    = rs2_val;
                rd     = 5'd0;
                branch = 1'b1;
                funct3 = branch_funct3(f3_s);
                if (f3_s[2:1] == 2'b00) begin
                    insn30 = 1'b1;
                end else if (f3_s[2:1] == 2'b01) begin
                    illegal = 1'b1;
                end else begin
                    insn30 = 1'b0;
                end
            end
            default: begin
                illegal = 1'b1;
                rd      = 5'd0;
            end
        endcase
    end

endmodule

// File: rtl/yarvi_alu_issue.sv
// Operand-issue stage in front of the combinational ALU. Decodes one
// instruction per in_valid/in_ready handshake and holds the ALU selector
// inputs in a valid/ready register (1-cycle latency, full throughput).
//   clock, reset_n (async, active-low), flush (sync kill of held entries)
//   in_valid/in_ready, in_insn, in_pc, in_rs1_val, in_rs2_val
//   out_valid/out_ready, out_insn30, out_funct3, out_op1, out_op2,
//   out_rd, out_branch, out_illegal
// Build option: YARVI_ALU_ISSUE_SKID_EN adds a skid slot so in_ready is a
// register with no combinational path from out_ready.
module yarvi_alu_issue
    import yarvi_alu_issue_pkg::*;
#(
    parameter int XLEN = ISSUE_XLEN
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_insn30,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [4:0]      out_rd,
    output logic            out_branch,
    output logic            out_illegal
);

    // Entry layout: {insn30, funct3, op1, op2, rd, branch, illegal}
    localparam int ENT_W = 1 + 3 + XLEN + XLEN + 5 + 1 + 1;

    logic            dec_insn30_s;
    logic [2:0]      dec_funct3_s;
    logic [XLEN-1:0] dec_op1_s;
    logic [XLEN-1:0] dec_op2_s;
    logic [4:0]      dec_rd_s;
    logic            dec_branch_s;
    logic            dec_illegal_s;
    logic [ENT_W-1:0] dec_ent_s;

    logic             valid_r;
    logic [ENT_W-1:0] main_r;
    logic             accept_s;
    logic             main_free_s;

    yarvi_alu_decode #(.XLEN(XLEN)) u_decode (
        .insn    (in_insn),
        .pc      (in_pc),
        .rs1_val (in_rs1_val),
        .rs2_val (in_rs2_val),
        .insn30  (dec_insn30_s),
        .funct3  (dec_funct3_s),
        .op1     (dec_op1_s),
        .op2     (dec_op2_s),
        .rd      (dec_rd_s),
        .branch  (dec_branch_s),
        .illegal (dec_illegal_s)
    );

    assign dec_ent_s   = {dec_insn30_s, dec_funct3_s, dec_op1_s, dec_op2_s,
                          dec_rd_s, dec_branch_s, dec_illegal_s};
    assign accept_s    = in_valid && in_ready;
    assign main_free_s = !valid_r || out_ready;

`ifdef YARVI_ALU_ISSUE_SKID_EN
    logic             skid_valid_r;
    logic [ENT_W-1:0] skid_r;
    logic             in_ready_r;

    assign in_ready = in_ready_r;

    // Main register plus skid slot; the skid entry always drains before
    // any new input so ordering is preserved.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_r      <= 1'b0;
            main_r       <= '0;
            skid_valid_r <= 1'b0;
            skid_r       <= '0;
            in_ready_r   <= 1'b1;
        end else if (flush) begin
            valid_r      <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (skid_valid_r) begin
            // in_ready is low here, so no new input can arrive.
            if (main_free_s) begin
                main_r       <= skid_r;
                valid_r      <= 1'b1;
                skid_valid_r <= 1'b0;
                in_ready_r   <= 1'b1;
            end
        end else if (accept_s) begin
            if (main_free_s) begin
                main_r  <= dec_ent_s;
                valid_r <= 1'b1;
            end else begin
                skid_r       <= dec_ent_s;
                skid_valid_r <= 1'b1;
                in_ready_r   <= 1'b0;
            end
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end
    end
`else
    assign in_ready = main_free_s;

    // Single pipeline register; accept and retire on one edge replace the
    // entry without a bubble.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= 1'b0;
            main_r  <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            main_r  <= dec_ent_s;
            valid_r <= 1'b1;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end
    end
`endif

    assign out_valid = valid_r;
    assign {out_insn30, out_funct3, out_op1, out_op2,
            out_rd, out_branch, out_illegal} = main_r;

endmodule

// File: tb/tb_yarvi_alu_issue.sv
// Self-checking bench for yarvi_alu_issue: directed decode cases, a
// stalled stream, flush, reset mid-stall and a randomized run, all checked
// against a queue-based reference model of the stage.
module tb_yarvi_alu_issue;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_insn;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic        out_insn30;
    logic [2:0]  out_funct3;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [4:0]  out_rd;
    logic        out_branch;
    logic        out_illegal;

    yarvi_alu_issue #(.XLEN(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_insn     (in_insn),
        .in_pc       (in_pc),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_insn30  (out_insn30),
        .out_funct3  (out_funct3),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_rd      (out_rd),
        .out_branch  (out_branch),
        .out_illegal (out_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        insn30;
        logic [2:0]  funct3;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        branch;
        logic        illegal;
    } exp_t;

    exp_t model_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   retired  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: ALU inputs derived straight from the RV32I field rules.
    function automatic exp_t ref_decode(input logic [31:0] insn, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t        e;
        int unsigned f3;
        logic [31:0] imm_i;
        logic [31:0] imm_u;
        f3    = insn[14:12];
        imm_i = {20'd0, insn[31:20]};
        if (insn[31]) imm_i = imm_i - 32'd4096;
        imm_u = insn & 32'hFFFF_F000;
        e.insn30 = 1'b0; e.funct3 = 3'd0; e.op1 = 32'd0; e.op2 = 32'd0;
        e.rd = insn[11:7]; e.branch = 1'b0; e.illegal = 1'b0;
        case (insn[6:0])
            7'h33: begin e.funct3 = 3'(f3); e.insn30 = insn[30]; e.op1 = rs1; e.op2 = rs2; end
            7'h13: begin
                e.funct3 = 3'(f3); e.op1 = rs1; e.op2 = imm_i;
                e.insn30 = (f3 == 5) ? insn[30] : 1'b0;
            end
            7'h37: e.op2 = imm_u;
            7'h17: begin e.op1 = pc; e.op2 = imm_u; end
            7'h6F, 7'h67: begin e.op1 = pc; e.op2 = 32'd4; end
            7'h63: begin
                e.op1 = rs1; e.op2 = rs2; e.rd = 5'd0; e.branch = 1'b1;
                if (f3 == 0 || f3 == 1)      e.insn30 = 1'b1;
                else if (f3 == 4 || f3 == 5) e.funct3 = 3'd2;
                else if (f3 == 6 || f3 == 7) e.funct3 = 3'd3;
                else                         e.illegal = 1'b1;
            end
            default: begin e.illegal = 1'b1; e.rd = 5'd0; end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [6:0]  ops [7];
        logic [31:0] r;
        int          k;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63};
        r = $urandom;
        k = $urandom_range(0, 8);
        if (k >= 7) return r;
        return {r[31:7], ops[k]};
    endfunction

    // One clock: check outputs against the model, then advance the model.
    task automatic step(output bit acc);
        exp_t e;
        bit   ret;
        bit   fl;
        @(negedge clock);
        check_eq("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
`ifdef YARVI_ALU_ISSUE_SKID_EN
        check_eq("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
`else
        check_eq("in_ready", 32'(in_ready), 32'(model_q.size() == 0 || out_ready));
`endif
        if (model_q.size() != 0) begin
            check_eq("insn30",  32'(out_insn30),  32'(model_q[0].insn30));
            check_eq("funct3",  32'(out_funct3),  32'(model_q[0].funct3));
            check_eq("op1",     out_op1,          model_q[0].op1);
            check_eq("op2",     out_op2,          model_q[0].op2);
            check_eq("rd",      32'(out_rd),      32'(model_q[0].rd));
            check_eq("branch",  32'(out_branch),  32'(model_q[0].branch));
            check_eq("illegal", 32'(out_illegal), 32'(model_q[0].illegal));
        end
        acc = in_valid && in_ready;
        ret = out_valid && out_ready;
        fl  = flush;
        e   = ref_decode(in_insn, in_pc, in_rs1_val, in_rs2_val);
        @(posedge clock);
        if (fl) begin
            model_q.delete();
        end else begin
            if (ret && model_q.size() != 0) begin
                void'(model_q.pop_front());
                retired++;
            end
            if (acc) model_q.push_back(e);
        end
        #1;
    endtask

    // Offer one instruction with out_ready high; returns once accepted.
    task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        in_valid = 1'b1; in_insn = insn; in_pc = 32'h0000_1000;
        in_rs1_val = rs1; in_rs2_val = rs2; out_ready = 1'b1;
        while (!acc && n < 10) begin
            step(acc);
            n++;
        end
        check_eq("accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_valid"},  32'(out_valid), 32'd0);
        check_eq({tag, "_ready"},  32'(in_ready),  32'd1);
        check_eq({tag, "_data"},   out_op1 | out_op2, 32'd0);
        check_eq({tag, "_sel"},    {23'd0, out_insn30, out_funct3, out_rd}, 32'd0);
        check_eq({tag, "_flags"},  32'({out_branch, out_illegal}), 32'd0);
    endtask

    logic [31:0] stream [4];
    logic [31:0] tmp;
    bit          acc;
    int          sent;
    int          base;

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_insn = 32'd0; in_pc = 32'd0; in_rs1_val = 32'd0; in_rs2_val = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_state("reset");
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Directed decode cases.
        issue(32'hFFF0_8293, 32'd7, 32'd0);
        check_eq("addi_funct3", 32'(out_funct3), 32'd0);
        check_eq("addi_insn30", 32'(out_insn30), 32'd0);
        check_eq("addi_op2",    out_op2, 32'hFFFF_FFFF);
        check_eq("addi_rd",     32'(out_rd), 32'd5);
        check_eq("addi_alu",    out_op1 + out_op2, 32'd6);

        issue(32'h4041_5193, 32'h8000_0000, 32'd0);
        check_eq("srai_funct3", 32'(out_funct3), 32'd5);
        check_eq("srai_insn30", 32'(out_insn30), 32'd1);
        check_eq("srai_op2",    out_op2, 32'h0000_0404);
        tmp = $signed(out_op1) >>> out_op2[4:0];
        check_eq("srai_alu",    tmp, 32'hF800_0000);

        issue(32'h0020_E063, 32'd1, 32'hFFFF_FFFF);
        check_eq("bltu_funct3", 32'(out_funct3), 32'd3);
        check_eq("bltu_rd",     32'(out_rd), 32'd0);
        check_eq("bltu_branch", 32'(out_branch), 32'd1);

        issue(32'h0020_8063, 32'd9, 32'd9);
        check_eq("beq_funct3", 32'(out_funct3), 32'd0);
        check_eq("beq_insn30", 32'(out_insn30), 32'd1);

        issue(32'h0000_007F, 32'd3, 32'd4);
        check_eq("illegal_flag", 32'(out_illegal), 32'd1);
        check_eq("illegal_ops",  out_op1 | out_op2, 32'd0);
        step(acc);

        // Stream of 4 with the consumer stalled on cycles 2 and 3.
        stream = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213};
        base = retired;
        sent = 0;
        for (int c = 1; c < 30 && (retired - base) < 4; c++) begin
            out_ready  = !(c == 2 || c == 3);
            in_valid   = (sent < 4);
            in_insn    = stream[sent < 4 ? sent : 3];
            in_rs1_val = 32'(c);
            step(acc);
            if (acc) sent++;
        end
        check_eq("stream_retired", 32'(retired - base), 32'd4);
        check_eq("stream_drained", 32'(model_q.size()), 32'd0);

        // Flush with one entry held and a new input offered.
        in_valid = 1'b1; in_insn = 32'h0050_0293; out_ready = 1'b0;
        step(acc);
        in_insn = 32'h0060_0313; out_ready = 1'b1; flush = 1'b1;
        step(acc);
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_valid", 32'(out_valid), 32'd0);
        repeat (3) step(acc);

        // Reset in the middle of a stall.
        in_valid = 1'b1; in_insn = 32'h0070_0393; out_ready = 1'b0;
        step(acc);
        step(acc);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
        model_q.delete();
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_reset_state("rst_mid");

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 24) == 0);
            in_insn    = rand_insn();
            in_pc      = $urandom & 32'hFFFF_FFFC;
            in_rs1_val = $urandom;
            in_rs2_val = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            step(acc);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step(acc);
        check_eq("final_drained", 32'(model_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
